// File: rtl/demux_12_queue.sv
// Registered 1:2 demultiplexer with one small FIFO per consumer lane.
// Ports: clk, rst, flush, in_valid/in_ready/in_data/select, outN_valid/ready/data/level.
module demux_12_queue #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2,
   localparam int PW = $clog2(DEPTH),
   localparam int LW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             select,
   output logic             out0_valid,
   input  logic             out0_ready,
   output logic [WIDTH-1:0] out0_data,
   output logic [LW-1:0]    out0_level,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [WIDTH-1:0] out1_data,
   output logic [LW-1:0]    out1_level
);

   localparam logic [LW-1:0] FULL = LW'(DEPTH);

   logic             accept;
   logic             push [2];
   logic             pop  [2];
   logic             rdy  [2];
   logic             vld  [2];
   logic [WIDTH-1:0] dat  [2];
   logic [LW-1:0]    lvl  [2];

   // Full lanes refuse even when popping this cycle; no pass-through.
   assign in_ready = !flush && (select ? (lvl[1] != FULL)
                                       : (lvl[0] != FULL));
   assign accept   = in_valid && in_ready;

   assign push[0] = accept && !select;
   assign push[1] = accept && select;

   assign rdy[0] = out0_ready;
   assign rdy[1] = out1_ready;

   // Flush overrides any same-cycle pop.
   assign pop[0] = vld[0] && rdy[0] && !flush;
   assign pop[1] = vld[1] && rdy[1] && !flush;

   for (genvar n = 0; n < 2; n++) begin : g_lane
      logic [WIDTH-1:0] mem_q [DEPTH];
      logic [PW-1:0]    wr_q, wr_d;
      logic [PW-1:0]    rd_q, rd_d;
      logic [LW-1:0]    lvl_q, lvl_d;

      always_comb begin
         wr_d  = wr_q;
         rd_d  = rd_q;
         lvl_d = lvl_q;
         if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            lvl_d = '0;
         end else begin
            // Power-of-two depth: pointers wrap naturally.
            if (push[n]) wr_d = wr_q + 1'b1;
            if (pop[n])  rd_d = rd_q + 1'b1;
            if (push[n] && !pop[n]) lvl_d = lvl_q + 1'b1;
            if (!push[n] && pop[n]) lvl_d = lvl_q - 1'b1;
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
         end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            lvl_q <= lvl_d;
         end
      end

      // Storage needs no reset; level gates visibility.
      always_ff @(posedge clk) begin
         if (push[n]) mem_q[wr_q] <= in_data;
      end

      assign lvl[n] = lvl_q;
      assign vld[n] = (lvl_q != '0);
      assign dat[n] = vld[n] ? mem_q[rd_q] : '0;
   end

   assign out0_valid = vld[0];
   assign out0_data  = dat[0];
   assign out0_level = lvl[0];
   assign out1_valid = vld[1];
   assign out1_data  = dat[1];
   assign out1_level = lvl[1];

endmodule

// File: tb/tb_demux_12_queue.sv
// Bench for demux_12_queue: vector table plus async-reset sequence.
// Drives inputs after the rising edge, samples mid-cycle.
module tb_demux_12_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        select;
   logic        out0_valid, out0_ready;
   logic [31:0] out0_data;
   logic [1:0]  out0_level;
   logic        out1_valid, out1_ready;
   logic [31:0] out1_data;
   logic [1:0]  out1_level;

   int checks   = 0;
   int failures = 0;

   demux_12_queue #(.WIDTH(32), .DEPTH(2)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .select(select),
      .out0_valid(out0_valid), .out0_ready(out0_ready),
      .out0_data(out0_data), .out0_level(out0_level),
      .out1_valid(out1_valid), .out1_ready(out1_ready),
      .out1_data(out1_data), .out1_level(out1_level)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        fl, iv, sel;
      logic [31:0] din;
      logic        r0, r1;
      logic        rdy, v0;
      logic [31:0] d0;
      logic [1:0]  l0;
      logic        v1;
      logic [31:0] d1;
      logic [1:0]  l1;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(
      input logic fl, iv, sel, input logic [31:0] din,
      input logic r0, r1, rdy, v0, input logic [31:0] d0,
      input logic [1:0] l0, input logic v1,
      input logic [31:0] d1, input logic [1:0] l1);
      vec_t v;
      v.fl = fl; v.iv = iv; v.sel = sel; v.din = din;
      v.r0 = r0; v.r1 = r1; v.rdy = rdy; v.v0 = v0;
      v.d0 = d0; v.l0 = l0; v.v1 = v1; v.d1 = d1; v.l1 = l1;
      return v;
   endfunction

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic fl, iv, sel,
                        input logic [31:0] din,
                        input logic r0, r1);
      flush = fl; in_valid = iv; select = sel;
      in_data = din; out0_ready = r0; out1_ready = r1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      drive(0, 0, 0, 32'h0, 0, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // fl iv sel din r0 r1 | rdy v0 d0 l0 v1 d1 l1
      tv.push_back(mk(0,0,0,32'h0,0,0, 1,0,32'h0,0,0,32'h0,0));
      tv.push_back(mk(0,1,1,32'hDEADBEEF,0,0,
                      1,0,32'h0,0,0,32'h0,0));
      tv.push_back(mk(0,0,0,32'h0,0,0,
                      1,0,32'h0,0,1,32'hDEADBEEF,1));
      tv.push_back(mk(0,0,0,32'h0,0,1,
                      1,0,32'h0,0,1,32'hDEADBEEF,1));
      tv.push_back(mk(0,1,0,32'h1,0,0, 1,0,32'h0,0,0,32'h0,0));
      tv.push_back(mk(0,1,0,32'h2,0,0, 1,1,32'h1,1,0,32'h0,0));
      tv.push_back(mk(0,1,0,32'h99,0,0, 0,1,32'h1,2,0,32'h0,0));
      tv.push_back(mk(0,1,1,32'h3,0,0, 1,1,32'h1,2,0,32'h0,0));
      tv.push_back(mk(0,1,0,32'h4,1,0, 0,1,32'h1,2,1,32'h3,1));
      tv.push_back(mk(0,1,0,32'h4,1,0, 1,1,32'h2,1,1,32'h3,1));
      tv.push_back(mk(0,0,0,32'h0,1,1, 1,1,32'h4,1,1,32'h3,1));
      tv.push_back(mk(0,1,0,32'h10,0,0, 1,0,32'h0,0,0,32'h0,0));
      for (int k = 1; k < 8; k++)
         tv.push_back(mk(0,1,0,32'h10 + k,1,0,
                         1,1,32'h10 + k - 1,1,0,32'h0,0));
      tv.push_back(mk(0,0,0,32'h0,1,0, 1,1,32'h17,1,0,32'h0,0));
      tv.push_back(mk(0,1,0,32'hA,0,0, 1,0,32'h0,0,0,32'h0,0));
      tv.push_back(mk(0,1,0,32'hB,0,0, 1,1,32'hA,1,0,32'h0,0));
      tv.push_back(mk(0,1,1,32'hC,0,0, 1,1,32'hA,2,0,32'h0,0));
      tv.push_back(mk(0,1,1,32'hD,0,0, 1,1,32'hA,2,1,32'hC,1));
      tv.push_back(mk(1,1,0,32'hBAD,1,1, 0,1,32'hA,2,1,32'hC,2));
      tv.push_back(mk(0,0,0,32'h0,0,0, 1,0,32'h0,0,0,32'h0,0));
      tv.push_back(mk(0,1,1,32'hE,0,0, 1,0,32'h0,0,0,32'h0,0));
      tv.push_back(mk(0,0,0,32'h0,0,1, 1,0,32'h0,0,1,32'hE,1));
      tv.push_back(mk(0,0,0,32'h0,0,0, 1,0,32'h0,0,0,32'h0,0));

      foreach (tv[i]) begin
         drive(tv[i].fl, tv[i].iv, tv[i].sel, tv[i].din,
               tv[i].r0, tv[i].r1);
         #3;
         chk($sformatf("v%0d_rdy", i), 32'(in_ready), 32'(tv[i].rdy));
         chk($sformatf("v%0d_v0", i), 32'(out0_valid), 32'(tv[i].v0));
         chk($sformatf("v%0d_d0", i), out0_data, tv[i].d0);
         chk($sformatf("v%0d_l0", i), 32'(out0_level), 32'(tv[i].l0));
         chk($sformatf("v%0d_v1", i), 32'(out1_valid), 32'(tv[i].v1));
         chk($sformatf("v%0d_d1", i), out1_data, tv[i].d1);
         chk($sformatf("v%0d_l1", i), 32'(out1_level), 32'(tv[i].l1));
         tick();
      end

      // Async reset mid-cycle with three words queued.
      drive(0, 1, 0, 32'h51, 0, 0); tick();
      drive(0, 1, 0, 32'h52, 0, 0); tick();
      drive(0, 1, 1, 32'h53, 0, 0); tick();
      drive(0, 0, 0, 32'h0, 0, 0);
      #1;
      chk("pre_rst_l0", 32'(out0_level), 32'd2);
      chk("pre_rst_l1", 32'(out1_level), 32'd1);
      chk("pre_rst_rdy", 32'(in_ready), 32'd0);
      rst = 1'b1;
      #1;
      chk("rst_v0", 32'(out0_valid), 32'd0);
      chk("rst_l0", 32'(out0_level), 32'd0);
      chk("rst_d0", out0_data, 32'h0);
      chk("rst_v1", 32'(out1_valid), 32'd0);
      chk("rst_l1", 32'(out1_level), 32'd0);
      chk("rst_d1", out1_data, 32'h0);
      chk("rst_rdy", 32'(in_ready), 32'd1);
      tick();
      rst = 1'b0;
      drive(0, 1, 0, 32'h77, 0, 0); tick();
      drive(0, 0, 0, 32'h0, 1, 0);
      #1;
      chk("post_rst_d0", out0_data, 32'h77);
      chk("post_rst_l0", 32'(out0_level), 32'd1);
      chk("post_rst_l1", 32'(out1_level), 32'd0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
